// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel coordinates, visible-area flag and VGA syncs.
// The sync and delayed-blank outputs are retimed to line up with renderer colour output.
module vga_timing_gen #(
    parameter int unsigned H_VISIBLE  = 640,
    parameter int unsigned H_FRONT    = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BACK     = 48,
    parameter int unsigned V_VISIBLE  = 480,
    parameter int unsigned V_FRONT    = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BACK     = 33,
    parameter int unsigned SYNC_DELAY = 2
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    input  logic       pix_en,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       blank,
    output logic       blank_d,
    output logic       hs,
    output logic       vs,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] X_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] Y_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic [9:0] next_x;
    logic [9:0] next_y;
    logic       next_blank;
    logic       next_hs;
    logic       next_vs;
    logic       next_origin;
    logic       hs_raw;
    logic       vs_raw;

    // Flags are derived from the next coordinates so they register alongside DrawX/DrawY.
    always_comb begin
        next_x = DrawX + 10'd1;
        next_y = DrawY;
        if (DrawX == X_LAST) begin
            next_x = '0;
            next_y = (DrawY == Y_LAST) ? '0 : DrawY + 10'd1;
        end
        next_blank  = (next_x < X_VIS) && (next_y < Y_VIS);
        next_hs     = !((next_x >= HS_START) && (next_x <= HS_END));
        next_vs     = !((next_y >= VS_START) && (next_y <= VS_END));
        next_origin = (next_x == '0) && (next_y == '0);
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            DrawX       <= X_LAST;
            DrawY       <= Y_LAST;
            blank       <= 1'b0;
            hs_raw      <= 1'b1;
            vs_raw      <= 1'b1;
            frame_start <= 1'b0;
            frame_count <= 8'hFF;
        end else begin
            frame_start <= 1'b0;
            if (pix_en) begin
                DrawX       <= next_x;
                DrawY       <= next_y;
                blank       <= next_blank;
                hs_raw      <= next_hs;
                vs_raw      <= next_vs;
                frame_start <= next_origin;
                if (next_origin) begin
                    frame_count <= frame_count + 8'd1;
                end
            end
        end
    end

    if (SYNC_DELAY == 0) begin : g_no_delay
        assign hs      = hs_raw;
        assign vs      = vs_raw;
        assign blank_d = blank;
    end else begin : g_delay
        // Each stage holds {hs, vs, blank}; it only shifts on advancing pixels.
        logic [2:0] stage [SYNC_DELAY];

        always_ff @(posedge vga_clk or negedge reset_n) begin
            if (!reset_n) begin
                for (int unsigned i = 0; i < SYNC_DELAY; i++) begin
                    stage[i] <= 3'b110;
                end
            end else if (pix_en) begin
                stage[0] <= {hs_raw, vs_raw, blank};
                for (int unsigned i = 1; i < SYNC_DELAY; i++) begin
                    stage[i] <= stage[i-1];
                end
            end
        end

        assign {hs, vs, blank_d} = stage[SYNC_DELAY-1];
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a shrunken 16x8 raster (delay-2 and delay-0 builds).
// Expected values come from a closed-form function of the number of advances since reset.
module tb_vga_timing_gen;

    localparam int HV = 8, HF = 2, HS = 3, HB = 3;
    localparam int VV = 4, VF = 1, VS = 2, VB = 1;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FT = HT * VT;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       pix_en = 1'b0;
    logic [9:0] x2, y2, x0, y0;
    logic       blank2, blank_d2, hs2, vs2, fs2;
    logic       blank0, blank_d0, hs0, vs0, fs0;
    logic [7:0] fc2, fc0;

    int n = 0;
    bit last_adv = 0;
    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_DELAY(2)
    ) dut (
        .vga_clk(clk), .reset_n(reset_n), .pix_en(pix_en), .DrawX(x2), .DrawY(y2),
        .blank(blank2), .blank_d(blank_d2), .hs(hs2), .vs(vs2), .frame_start(fs2),
        .frame_count(fc2)
    );

    vga_timing_gen #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_DELAY(0)
    ) dut0 (
        .vga_clk(clk), .reset_n(reset_n), .pix_en(pix_en), .DrawX(x0), .DrawY(y0),
        .blank(blank0), .blank_d(blank_d0), .hs(hs0), .vs(vs0), .frame_start(fs0),
        .frame_count(fc0)
    );

    // m = advances since reset; m <= 0 means the reset state.
    function automatic logic [9:0] ex_x(input int m);
        return (m <= 0) ? 10'(HT - 1) : 10'(((m - 1) % FT) % HT);
    endfunction
    function automatic logic [9:0] ex_y(input int m);
        return (m <= 0) ? 10'(VT - 1) : 10'(((m - 1) % FT) / HT);
    endfunction
    function automatic logic ex_vis(input int m);
        return (m <= 0) ? 1'b0 : (ex_x(m) < 10'(HV)) && (ex_y(m) < 10'(VV));
    endfunction
    function automatic logic ex_hs(input int m);
        return (m <= 0) ? 1'b1 : !((ex_x(m) >= 10'(HV + HF)) && (ex_x(m) <= 10'(HV + HF + HS - 1)));
    endfunction
    function automatic logic ex_vs(input int m);
        return (m <= 0) ? 1'b1 : !((ex_y(m) >= 10'(VV + VF)) && (ex_y(m) <= 10'(VV + VF + VS - 1)));
    endfunction
    function automatic logic [7:0] ex_fc(input int m);
        return (m <= 0) ? 8'hFF : 8'(((m - 1) / FT) % 256);
    endfunction
    function automatic logic ex_fs(input int m, input bit adv);
        return adv && (m >= 1) && (((m - 1) % FT) == 0);
    endfunction

    task automatic tick(input logic en);
        pix_en = en;
        @(posedge clk);
        if (en) n++;
        last_adv = en;
        #1;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        n_checks += 8;
        if (x2 !== 10'd15) begin n_fail++; $display("FAIL rst_x got %0d exp 15", x2); end
        if (y2 !== 10'd7) begin n_fail++; $display("FAIL rst_y got %0d exp 7", y2); end
        if ({blank2, blank_d2} !== 2'b00) begin
            n_fail++; $display("FAIL rst_blank got %b exp 00", {blank2, blank_d2});
        end
        if ({hs2, vs2} !== 2'b11) begin n_fail++; $display("FAIL rst_sync got %b exp 11", {hs2, vs2}); end
        if (fs2 !== 1'b0) begin n_fail++; $display("FAIL rst_fs got %b exp 0", fs2); end
        if (fc2 !== 8'hFF) begin n_fail++; $display("FAIL rst_fc got %h exp ff", fc2); end
        if ({hs0, vs0, blank_d0} !== 3'b110) begin
            n_fail++; $display("FAIL rst_d0 got %b exp 110", {hs0, vs0, blank_d0});
        end
        if (fc0 !== 8'hFF) begin n_fail++; $display("FAIL rst_fc0 got %h exp ff", fc0); end
    endtask

    task automatic release_reset;
        #3 reset_n = 1'b1;
        n = 0;
        last_adv = 0;
    endtask

    task automatic test_first_advance;
        tick(1'b1);
        n_checks += 6;
        if ({x2, y2} !== 20'd0) begin n_fail++; $display("FAIL first_xy got %0d,%0d exp 0,0", x2, y2); end
        if (blank2 !== 1'b1) begin n_fail++; $display("FAIL first_blank got %b exp 1", blank2); end
        if (fs2 !== 1'b1) begin n_fail++; $display("FAIL first_fs got %b exp 1", fs2); end
        if (fc2 !== 8'h00) begin n_fail++; $display("FAIL first_fc got %h exp 00", fc2); end
        if ({hs2, vs2} !== 2'b11) begin n_fail++; $display("FAIL first_sync got %b exp 11", {hs2, vs2}); end
        if (blank_d2 !== 1'b0) begin n_fail++; $display("FAIL first_blank_d got %b exp 0", blank_d2); end
    endtask

    task automatic test_line;
        int hs_low = 0;
        for (int i = 0; i < HT; i++) begin
            tick(1'b1);
            if (hs2 === 1'b0) hs_low++;
            n_checks += 4;
            if ({x2, y2} !== {ex_x(n), ex_y(n)}) begin
                n_fail++; $display("FAIL line_xy n=%0d got %0d,%0d exp %0d,%0d", n, x2, y2, ex_x(n), ex_y(n));
            end
            if (blank2 !== ex_vis(n)) begin
                n_fail++; $display("FAIL line_blank n=%0d got %b exp %b", n, blank2, ex_vis(n));
            end
            if ({hs2, blank_d2} !== {ex_hs(n - 2), ex_vis(n - 2)}) begin
                n_fail++; $display("FAIL line_hs_d n=%0d got %b exp %b", n, {hs2, blank_d2},
                                   {ex_hs(n - 2), ex_vis(n - 2)});
            end
            if (hs0 !== ex_hs(n)) begin n_fail++; $display("FAIL line_hs0 n=%0d got %b exp %b", n, hs0, ex_hs(n)); end
        end
        n_checks++;
        if (hs_low != HS) begin n_fail++; $display("FAIL line_hs_width got %0d exp %0d", hs_low, HS); end
    endtask

    task automatic test_frames;
        int last_fs = 1;
        int pulses = 0;
        while (n < 3 * FT + 2) begin
            tick(1'b1);
            n_checks += 4;
            if (fs2 !== ex_fs(n, last_adv)) begin
                n_fail++; $display("FAIL frm_fs n=%0d got %b exp %b", n, fs2, ex_fs(n, last_adv));
            end
            if (fc2 !== ex_fc(n)) begin n_fail++; $display("FAIL frm_fc n=%0d got %h exp %h", n, fc2, ex_fc(n)); end
            if (vs2 !== ex_vs(n - 2)) begin
                n_fail++; $display("FAIL frm_vs n=%0d got %b exp %b", n, vs2, ex_vs(n - 2));
            end
            if (blank2 && y2 >= 10'(VV)) begin
                n_fail++; $display("FAIL frm_blank_vbl n=%0d got 1 exp 0", n);
            end
            if (fs2 === 1'b1) begin
                pulses++;
                n_checks++;
                if (n - last_fs != FT) begin
                    n_fail++; $display("FAIL frm_period got %0d exp %0d", n - last_fs, FT);
                end
                last_fs = n;
            end
        end
        n_checks++;
        if (pulses != 3) begin n_fail++; $display("FAIL frm_pulses got %0d exp 3", pulses); end
    endtask

    task automatic test_stall;
        logic prev_fs = 1'b0;
        for (int k = 0; k < 4 * FT; k++) begin
            tick((k % 4 == 0) || (k % 4 == 3));
            n_checks += 4;
            if ({x2, y2} !== {ex_x(n), ex_y(n)}) begin
                n_fail++; $display("FAIL stall_xy n=%0d got %0d,%0d exp %0d,%0d", n, x2, y2, ex_x(n), ex_y(n));
            end
            if ({hs2, vs2, blank_d2, blank2} !== {ex_hs(n - 2), ex_vs(n - 2), ex_vis(n - 2), ex_vis(n)}) begin
                n_fail++; $display("FAIL stall_flags n=%0d got %b", n, {hs2, vs2, blank_d2, blank2});
            end
            if ({fs2, fc2} !== {ex_fs(n, last_adv), ex_fc(n)}) begin
                n_fail++; $display("FAIL stall_fs n=%0d got %b/%h exp %b/%h", n, fs2, fc2,
                                   ex_fs(n, last_adv), ex_fc(n));
            end
            if (prev_fs && fs2) begin n_fail++; $display("FAIL stall_fs_width n=%0d got 2 exp 1", n); end
            prev_fs = fs2;
        end
    endtask

    task automatic test_async_reset;
        while (((n - 1) % FT) != 2 * HT + 5) tick(1'b1);
        #2 reset_n = 1'b0;
        #1;
        n_checks += 3;
        if ({x2, y2} !== {10'd15, 10'd7}) begin
            n_fail++; $display("FAIL arst_xy got %0d,%0d exp 15,7", x2, y2);
        end
        if ({blank2, blank_d2, hs2, vs2, fs2} !== 5'b00110) begin
            n_fail++; $display("FAIL arst_flags got %b exp 00110", {blank2, blank_d2, hs2, vs2, fs2});
        end
        if (fc2 !== 8'hFF) begin n_fail++; $display("FAIL arst_fc got %h exp ff", fc2); end
        @(posedge clk);
        #1;
        n_checks++;
        if (x2 !== 10'd15) begin n_fail++; $display("FAIL arst_hold got %0d exp 15", x2); end
        release_reset();
        test_first_advance();
        test_line();
    endtask

    task automatic test_fc_wrap;
        while (n < 256 * FT + 3) begin
            tick(1'b1);
            n_checks += 2;
            if ({hs0, vs0, blank_d0} !== {ex_hs(n), ex_vs(n), ex_vis(n)}) begin
                n_fail++; $display("FAIL d0_sync n=%0d got %b exp %b", n, {hs0, vs0, blank_d0},
                                   {ex_hs(n), ex_vs(n), ex_vis(n)});
            end
            if (fc0 !== ex_fc(n)) begin n_fail++; $display("FAIL d0_fc n=%0d got %h exp %h", n, fc0, ex_fc(n)); end
            if (n == 255 * FT + 1) begin
                n_checks++;
                if ({fs0, fc0} !== {1'b1, 8'hFF}) begin
                    n_fail++; $display("FAIL fc_255 got %b/%h exp 1/ff", fs0, fc0);
                end
            end
            if (n == 256 * FT + 1) begin
                n_checks++;
                if ({fs0, fc0, x0, y0} !== {1'b1, 8'h00, 20'd0}) begin
                    n_fail++; $display("FAIL fc_wrap got %b/%h exp 1/00", fs0, fc0);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        release_reset();
        test_first_advance();
        test_line();
        test_frames();
        test_stall();
        test_async_reset();
        test_fc_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
